// File: rtl/access_sched_rr.sv
// Round-robin access scheduler: a binary tree of 2-input arbiters feeding a one-entry valid/ready output register.
// Optional feature macro: ARB_LOCK_EN (adds the lock port and a LOCKED state that pins the grant to one requester).
module access_sched_rr #(
  parameter int  NUM_REQ    = 8,
  parameter int  DATA_WIDTH = 132,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_IN,
  output logic [NUM_REQ-1:0]            serv,
  output logic [DATA_WIDTH-1:0]         data_OUT,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          active,
  output logic                          conflict
`ifdef ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]            lock
`endif
);

  // Handshake: a word moves downstream on a cycle where out_valid & out_ready are both high;
  // data_OUT/out_idx are held unchanged while out_valid & !out_ready.

  localparam int LEAVES = 1 << $clog2(NUM_REQ);
  localparam int NODES  = 2 * LEAVES;
  localparam int PRI_W  = (LEAVES > 1) ? LEAVES - 1 : 1;

  // Heap numbering: node 1 is the root, node n has children 2n/2n+1, leaves sit at LEAVES+i.
  // Per-internal-node vectors (pri, conf, pick_r, on_path) store node n at bit n-1.
  logic [LEAVES-1:0]     req_pad;
  logic [NODES-1:1]      node_act;
  logic [IDX_W-1:0]      node_idx [NODES-1:1];
  logic [PRI_W-1:0]      pri;
  logic [PRI_W-1:0]      conf;
  logic [PRI_W-1:0]      pick_r;
  logic [PRI_W-1:0]      on_path;

  logic                  cand_act;
  logic [IDX_W-1:0]      cand_idx;
  logic                  freeze;
  logic                  load;
  logic [DATA_WIDTH-1:0] sel_data;

  assign req_pad = LEAVES'(req);

  always_comb begin
    node_act = '0;
    conf     = '0;
    pick_r   = '0;
    for (int n = 1; n < NODES; n++) node_idx[n] = '0;
    for (int i = 0; i < LEAVES; i++) begin
      node_act[LEAVES+i] = req_pad[i];
      node_idx[LEAVES+i] = IDX_W'(i);
    end
    for (int n = LEAVES - 1; n >= 1; n--) begin
      node_act[n]  = node_act[2*n] | node_act[2*n+1];
      conf[n-1]    = node_act[2*n] & node_act[2*n+1];
      pick_r[n-1]  = node_act[2*n+1] & (~node_act[2*n] | pri[n-1]);
      node_idx[n]  = pick_r[n-1] ? node_idx[2*n+1] : node_idx[2*n];
    end
  end

  // Mark the nodes the winning request travels through, root first.
  always_comb begin
    on_path    = '0;
    on_path[0] = 1'b1;
    for (int n = 2; n < LEAVES; n++) begin
      on_path[n-1] = on_path[n/2-1] & (((n % 2) == 1) ? pick_r[n/2-1] : ~pick_r[n/2-1]);
    end
  end

`ifdef ARB_LOCK_EN
  typedef enum logic {LK_FREE, LK_HELD} lock_state_t;
  lock_state_t      lock_state;
  logic [IDX_W-1:0] lock_idx;
  logic             cand_lock;

  always_comb begin
    cand_idx = node_idx[1];
    cand_act = node_act[1];
    if (lock_state == LK_HELD) begin
      cand_idx = lock_idx;
      cand_act = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lock_idx == IDX_W'(i)) cand_act = req[i];
      end
    end
    cand_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_idx == IDX_W'(i)) cand_lock = lock[i];
    end
  end

  assign freeze = (lock_state == LK_HELD);

  // Every delivered beat decides the next state from that requester's lock bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= LK_FREE;
      lock_idx   <= '0;
    end else if (load) begin
      lock_state <= cand_lock ? LK_HELD : LK_FREE;
      lock_idx   <= cand_idx;
    end
  end
`else
  assign cand_idx = node_idx[1];
  assign cand_act = node_act[1];
  assign freeze   = 1'b0;
`endif

  assign load     = cand_act & (~out_valid | out_ready) & ~rst;
  assign active   = |req;
  assign conflict = |conf;

  always_comb begin
    serv     = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_idx == IDX_W'(i)) begin
        serv[i]  = load;
        sel_data = data_IN[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only conflicting nodes on the granted path flip, so the loser there wins next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri <= '0;
    end else if (load && !freeze) begin
      pri <= pri ^ (on_path & conf);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_OUT  <= '0;
      out_idx   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      data_OUT  <= sel_data;
      out_idx   <= cand_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_serv_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(serv));
  a_hold_stable: assert property (@(posedge clk)
    out_valid && !out_ready && !rst |=> $stable(data_OUT) && $stable(out_idx) && out_valid);

endmodule

// File: tb/tb_access_sched_rr.sv
// Bench for access_sched_rr: a 4-requester and a 5-requester instance checked every cycle against a
// top-down behavioural model of the round-robin tree, plus literal grant sequences.
module tb_access_sched_rr;
  localparam int DW = 132;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0]      req_a, serv_a, lock_a;
  logic [4*DW-1:0] din_a;
  logic [DW-1:0]   dout_a;
  logic [1:0]      idx_a;
  logic            ov_a, rdy_a, act_a, conf_a;
  logic [4:0]      req_b, serv_b, lock_b;
  logic [5*DW-1:0] din_b;
  logic [DW-1:0]   dout_b;
  logic [2:0]      idx_b;
  logic            ov_b, rdy_b, act_b, conf_b;

  access_sched_rr #(.NUM_REQ(4), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .data_IN(din_a), .serv(serv_a), .data_OUT(dout_a),
    .out_idx(idx_a), .out_valid(ov_a), .out_ready(rdy_a), .active(act_a), .conflict(conf_a)
`ifdef ARB_LOCK_EN
    , .lock(lock_a)
`endif
  );

  access_sched_rr #(.NUM_REQ(5), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .data_IN(din_b), .serv(serv_b), .data_OUT(dout_b),
    .out_idx(idx_b), .out_valid(ov_b), .out_ready(rdy_b), .active(act_b), .conflict(conf_b)
`ifdef ARB_LOCK_EN
    , .lock(lock_b)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_q_b[$];

  // Reference state per instance: node priorities by heap number, output register, lock.
  bit            m_pri[2][8];
  logic          m_ov[2];
  logic [DW-1:0] m_data[2];
  int            m_idx[2];
  bit            m_locked[2];
  int            m_lidx[2];

  task automatic check(input string tag, input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, name, got, exp, $time);
    end
  endtask

  function automatic bit sub_any(input logic [7:0] r, input int lo, input int cnt);
    for (int i = lo; i < lo + cnt; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Walk the tree from the root over index ranges; compare outputs, then advance the model.
  task automatic model_cycle(input int inst, input int n, input logic [7:0] r, input logic rdy,
                             input logic [7:0] lk, input logic [5*DW-1:0] d,
                             input logic [7:0] g_serv, input logic g_act, input logic g_conf,
                             input logic g_ov, input logic [DW-1:0] g_dout, input int g_idx);
    int p, lo, size, node, half, k;
    int tog[$];
    bit go_r, al, ar, cand, load;
    logic [7:0] e_serv;
    string tag;
    tag = (inst == 0) ? "a" : "b";
    check(tag, "out_valid", DW'(g_ov), DW'(m_ov[inst]));
    check(tag, "data_OUT", g_dout, m_data[inst]);
    check(tag, "out_idx", DW'(g_idx), DW'(m_idx[inst]));
    p = 1;
    while (p < n) p = p * 2;
    lo = 0; size = p; node = 1;
    while (size > 1) begin
      half = size / 2;
      al = sub_any(r, lo, half);
      ar = sub_any(r, lo + half, half);
      if (al && ar) begin
        go_r = m_pri[inst][node];
        tog.push_back(node);
      end else begin
        go_r = ar;
      end
      node = 2 * node + int'(go_r);
      if (go_r) lo = lo + half;
      size = half;
    end
    k = lo;
    cand = (r != 8'h0);
    if (m_locked[inst]) begin
      k = m_lidx[inst];
      cand = r[k];
      tog.delete();
    end
    load = cand && (!m_ov[inst] || rdy) && !rst;
    e_serv = load ? 8'(1 << k) : 8'h0;
    check(tag, "serv", DW'(g_serv), DW'(e_serv));
    check(tag, "active", DW'(g_act), DW'(r != 8'h0));
    check(tag, "conflict", DW'(g_conf), DW'($countones(r) >= 2));
    if (rst) begin
      m_ov[inst] = 1'b0; m_data[inst] = '0; m_idx[inst] = 0;
      m_locked[inst] = 1'b0; m_lidx[inst] = 0;
      for (int j = 0; j < 8; j++) m_pri[inst][j] = 1'b0;
    end else if (load) begin
      m_ov[inst] = 1'b1;
      m_data[inst] = d[k*DW +: DW];
      m_idx[inst] = k;
      foreach (tog[j]) m_pri[inst][tog[j]] = ~m_pri[inst][tog[j]];
      m_locked[inst] = lk[k];
      m_lidx[inst] = k;
    end else if (rdy) begin
      m_ov[inst] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 1'b0; m_data[i] = '0; m_idx[i] = 0; m_locked[i] = 1'b0; m_lidx[i] = 0;
    end
  end

  always @(negedge clk) begin
    model_cycle(0, 4, {4'b0, req_a}, rdy_a, {4'b0, lock_a}, {{DW{1'b0}}, din_a},
                {4'b0, serv_a}, act_a, conf_a, ov_a, dout_a, int'(idx_a));
    model_cycle(1, 5, {3'b0, req_b}, rdy_b, {3'b0, lock_b}, din_b,
                {3'b0, serv_b}, act_b, conf_b, ov_b, dout_b, int'(idx_b));
    if (ov_a && rdy_a && exp_q.size() > 0) check("a", "seq_idx", DW'(idx_a), exp_q.pop_front());
    if (ov_b && rdy_b && exp_q_b.size() > 0) check("b", "seq_idx", DW'(idx_b), exp_q_b.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t1[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
  int t5[8] = '{0, 4, 2, 4, 1, 4, 3, 4};
  logic [DW-1:0] w0;

  initial begin
    rst = 1'b1; req_a = '0; req_b = '0; din_a = '0; din_b = '0;
    rdy_a = 1'b1; rdy_b = 1'b1; lock_a = '0; lock_b = '0;
    repeat (2) tick();
    rst = 1'b0;
    #2;
    check("a", "rst_valid", DW'(ov_a), '0);
    check("a", "rst_data", dout_a, '0);
    check("a", "rst_idx", DW'(idx_a), '0);

    // All requesters held: fixed rotation on both trees, padded leaves never reached.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(DW'(t1[i]));
      exp_q_b.push_back(DW'(t5[i]));
    end
    req_a = 4'hF; req_b = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("a", "t1_serv", DW'(serv_a), DW'(1 << t1[i]));
      check("b", "t5_serv", DW'(serv_b), DW'(1 << t5[i]));
      tick();
    end
    req_a = '0; req_b = '0;
    repeat (2) tick();
    check("a", "t1_left", DW'(exp_q.size()), '0);
    check("b", "t5_left", DW'(exp_q_b.size()), '0);

    // Single requester: served the same cycle, word visible next cycle.
    din_a[2*DW +: DW] = DW'(8'hA5);
    req_a = 4'b0100;
    #2 check("a", "t2_serv", DW'(serv_a), DW'(4'b0100));
    tick();
    req_a = '0;
    #2;
    check("a", "t2_valid", DW'(ov_a), DW'(1'b1));
    check("a", "t2_data", dout_a, DW'(8'hA5));
    check("a", "t2_idx", DW'(idx_a), DW'(2));
    tick();

    // Stall: first word held while the next requester waits.
    for (int i = 0; i < 4; i++) din_a[i*DW +: DW] = rand_word();
    w0 = din_a[0 +: DW];
    rdy_a = 1'b0; req_a = 4'b0011;
    #2 check("a", "t3_serv0", DW'(serv_a), DW'(4'b0001));
    tick();
    for (int i = 0; i < 5; i++) begin
      din_a[DW +: DW] = rand_word();
      #2;
      check("a", "t3_stall_serv", DW'(serv_a), '0);
      check("a", "t3_stall_data", dout_a, w0);
      tick();
    end
    rdy_a = 1'b1;
    #2 check("a", "t3_release_serv", DW'(serv_a), DW'(4'b0010));
    tick();
    req_a = '0;
    repeat (2) tick();

    // Reset while stalled drops the held word; first grant afterwards goes to 0.
    rdy_a = 1'b0; req_a = 4'b0011;
    repeat (2) tick();
    rst = 1'b1;
    #2 check("a", "t4_rst_serv", DW'(serv_a), '0);
    tick();
    rst = 1'b0; req_a = 4'hF; rdy_a = 1'b1;
    #2;
    check("a", "t4_valid", DW'(ov_a), '0);
    check("a", "t4_data", dout_a, '0);
    check("a", "t4_serv", DW'(serv_a), DW'(4'b0001));
    tick();
    req_a = '0;
    repeat (2) tick();

`ifdef ARB_LOCK_EN
    // Lock on requester 1: it keeps the port until it presents lock=0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int t6[8] = '{0, 2, 1, 1, 1, 1, 3, 0};
      for (int i = 0; i < 8; i++) exp_q.push_back(DW'(t6[i]));
    end
    req_a = 4'hF; lock_a = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) lock_a = '0;
      tick();
    end
    req_a = '0;
    repeat (2) tick();
    check("a", "t6_left", DW'(exp_q.size()), '0);
`endif

    // Random traffic with back-pressure, data churn and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      req_a = 4'($urandom) | 4'($urandom);
      req_b = 5'($urandom) | 5'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 5'($urandom) & 5'($urandom);
      rdy_a = ($urandom_range(0, 3) != 0);
      rdy_b = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 4; i++) din_a[i*DW +: DW] = rand_word();
      for (int i = 0; i < 5; i++) din_b[i*DW +: DW] = rand_word();
`ifdef ARB_LOCK_EN
      lock_a = 4'($urandom) & 4'($urandom);
      lock_b = 5'($urandom) & 5'($urandom);
`endif
      tick();
    end
    rst = 1'b0; req_a = '0; req_b = '0; lock_a = '0; lock_b = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
